// File: rtl/tff_down_counter_pkg.sv
// Shared constants for the T flip-flop down-counter.
// Width limits and the zero reference used by the zero compare.
package tff_down_counter_pkg;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 16;

    localparam logic [WIDTH_MAX-1:0] ZERO_VAL = '0;

endpackage

// File: rtl/tff_down_counter_tff_cell.sv
// Single T flip-flop bit cell.
// Synchronous active-low reset clears the bit to 0.
module tff_cell (
    input  logic clk,
    input  logic reset,
    input  logic T,
    output logic Q
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            Q <= 1'b0;
        end else if (T) begin
            Q <= ~Q;
        end
    end

endmodule

// File: rtl/tff_down_counter.sv
// Synchronous down-counter built from T flip-flop cells.
// Parallel load, count enable, one-shot or auto-reload, registered tc.
module tff_down_counter
    import tff_down_counter_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] Q,
    output logic             zero,
    output logic             tc
);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("tff_down_counter: WIDTH out of range");
    end

    logic [WIDTH-1:0] reload_q;
    logic [WIDTH-1:0] t;
    logic [WIDTH-1:0] d;
    logic [WIDTH:0]   low_zero;
    logic             at_one;
    logic             dec;
    logic             rld;
    logic             set;

    assign zero   = (Q == ZERO_VAL[WIDTH-1:0]);
    assign at_one = (Q == WIDTH'(1));
    assign dec    = !load && en && !zero;
    assign rld    = !load && en && zero && auto_reload;
    assign set    = load || rld;
    assign d      = load ? load_val : reload_q;

    // Bit i toggles on decrement when every lower bit is 0 (borrow).
    always_comb begin
        low_zero    = '0;
        low_zero[0] = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            low_zero[i+1] = low_zero[i] & ~Q[i];
        end
        t = '0;
        for (int i = 0; i < WIDTH; i++) begin
            t[i] = set ? (Q[i] ^ d[i]) : (dec & low_zero[i]);
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        tff_cell u_cell (
            .clk   (clk),
            .reset (reset),
            .T     (t[i]),
            .Q     (Q[i])
        );
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            reload_q <= '0;
        end else if (load) begin
            reload_q <= load_val;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            tc <= 1'b0;
        end else begin
            tc <= dec && at_one;
        end
    end

endmodule

// File: tb/tb_tff_down_counter.sv
// Directed bench for tff_down_counter (WIDTH=3).
// Expected Q/tc are queued per step and checked after the edge.
module tb_tff_down_counter;

    logic       clk = 1'b0;
    logic       reset;
    logic       load;
    logic [2:0] load_val;
    logic       en;
    logic       auto_reload;
    logic [2:0] Q;
    logic       zero;
    logic       tc;

    typedef struct {
        logic [2:0] q;
        logic       tc;
        string      tag;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   tc_seen;

    always #5 clk = ~clk;

    tff_down_counter #(.WIDTH(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .load_val    (load_val),
        .en          (en),
        .auto_reload (auto_reload),
        .Q           (Q),
        .zero        (zero),
        .tc          (tc)
    );

    task automatic step(
        input logic       rst,
        input logic       ld,
        input logic [2:0] lv,
        input logic       e,
        input logic       ar,
        input logic [2:0] eq,
        input logic       etc,
        input string      tag
    );
        exp_t x;
        reset       = rst;
        load        = ld;
        load_val    = lv;
        en          = e;
        auto_reload = ar;
        exp_q.push_back('{q: eq, tc: etc, tag: tag});
        @(posedge clk);
        #1;
        x = exp_q.pop_front();
        total++;
        assert (Q === x.q) else begin
            bad++;
            $error("FAIL %s_q observed=%b expected=%b", x.tag, Q, x.q);
        end
        total++;
        assert (zero === (x.q == 3'b000)) else begin
            bad++;
            $error("FAIL %s_zero observed=%b expected=%b",
                   x.tag, zero, (x.q == 3'b000));
        end
        total++;
        assert (tc === x.tc) else begin
            bad++;
            $error("FAIL %s_tc observed=%b expected=%b", x.tag, tc, x.tc);
        end
        if (tc === 1'b1) tc_seen++;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset with load and en high
        step(0, 1, 3'b111, 1, 0, 3'b000, 0, "rst0");
        step(0, 1, 3'b111, 1, 0, 3'b000, 0, "rst1");
        step(1, 0, 3'b000, 1, 0, 3'b000, 0, "rst_rel");

        // 2: one-shot countdown from 5
        step(1, 1, 3'b101, 0, 0, 3'b101, 0, "os_ld");
        step(1, 0, 3'b000, 1, 0, 3'b100, 0, "os4");
        step(1, 0, 3'b000, 1, 0, 3'b011, 0, "os3");
        step(1, 0, 3'b000, 1, 0, 3'b010, 0, "os2");
        step(1, 0, 3'b000, 1, 0, 3'b001, 0, "os1");
        step(1, 0, 3'b000, 1, 0, 3'b000, 1, "os0");
        step(1, 0, 3'b000, 1, 0, 3'b000, 0, "os_hold0");
        step(1, 0, 3'b000, 1, 0, 3'b000, 0, "os_hold1");

        // 3: auto-reload period of 4 from stored 3
        step(1, 1, 3'b011, 0, 1, 3'b011, 0, "ar_ld");
        tc_seen = 0;
        for (int k = 1; k <= 12; k++) begin
            step(1, 0, 3'b000, 1, 1, 3'(3 - (k % 4)), (k % 4) == 3, "ar");
        end
        total++;
        assert (tc_seen == 3) else begin
            bad++;
            $error("FAIL ar_pulses observed=%0d expected=3", tc_seen);
        end

        // 4: enable gating
        step(1, 1, 3'b110, 0, 0, 3'b110, 0, "en_ld");
        step(1, 0, 3'b000, 1, 0, 3'b101, 0, "en_on0");
        step(1, 0, 3'b000, 0, 0, 3'b101, 0, "en_off0");
        step(1, 0, 3'b000, 1, 0, 3'b100, 0, "en_on1");
        step(1, 0, 3'b000, 0, 0, 3'b100, 0, "en_off1");

        // 5: load beats tc at Q=1, new reload value is used
        step(1, 1, 3'b010, 0, 1, 3'b010, 0, "lc_ld");
        step(1, 0, 3'b000, 1, 1, 3'b001, 0, "lc_at1");
        step(1, 1, 3'b111, 1, 1, 3'b111, 0, "lc_coll");
        for (int k = 6; k >= 1; k--) begin
            step(1, 0, 3'b000, 1, 1, 3'(k), 0, "lc_dn");
        end
        step(1, 0, 3'b000, 1, 1, 3'b000, 1, "lc_tc");
        step(1, 0, 3'b000, 1, 1, 3'b111, 0, "lc_rl");

        // 6: reset on the edge where Q would go 1 -> 0
        for (int k = 6; k >= 1; k--) begin
            step(1, 0, 3'b000, 1, 1, 3'(k), 0, "mr_dn");
        end
        step(0, 0, 3'b000, 1, 1, 3'b000, 0, "mr_rst");
        for (int k = 0; k < 4; k++) begin
            step(1, 0, 3'b000, 1, 1, 3'b000, 0, "mr_stay");
        end

        total++;
        assert (exp_q.size() == 0) else begin
            bad++;
            $error("FAIL sb_empty observed=%0d expected=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tff_down_counter.md
Name: tff_down_counter

Overview:
- Synchronous, parameterised binary down-counter built from T flip-flop cells: the counting-direction complement of the ripple up-counter.
- Supports parallel load, count enable, one-shot or auto-reload modes, and a registered terminal-count pulse.
- Used as a countdown timer or event divider that shares the same clock as the rest of the lab circuits; there is no ripple clocking.

Parameters:
- WIDTH, 3, counter width in bits (legal range 2..16)

Ports:
- clk  input  1  single system clock; all state changes on its rising edge
- reset  input  1  synchronous, active-low reset; sampled on rising clk
- load  input  1  when high, load load_val into the counter and the reload register
- load_val  input  WIDTH  value to load
- en  input  1  count enable; decrement by one per cycle while high
- auto_reload  input  1  1 = on reaching 0, the next enabled cycle reloads the stored value; 0 = one-shot, hold at 0
- Q  output  WIDTH  current count (registered)
- zero  output  1  combinational, equals (Q == 0)
- tc  output  1  registered terminal-count pulse, high for exactly one cycle

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-low on port reset. Asserting reset low at a rising clk edge clears all state on that edge.
- Reset values: Q=0, reload register=0, tc=0. zero therefore reads 1.
- Priority per edge, highest first: reset low > load > en > hold.
- load=1 (reset high):
  - Q <= load_val and reload register <= load_val; tc <= 0.
  - en is ignored that cycle; load takes effect in 1 cycle.
- en=1, load=0, Q>1: Q <= Q-1; tc <= 0.
- en=1, load=0, Q==1: Q <= 0; tc <= 1. tc is high in the same cycle Q first reads 0.
- en=1, load=0, Q==0:
  - auto_reload=1: Q <= reload register; tc <= 0.
  - auto_reload=0: Q holds at 0; tc <= 0.
  - No wrap to all-ones in either mode.
- Resulting sequences:
  - Auto-reload with stored value N: N, N-1, ..., 1, 0, N, ... gives period N+1 cycles with one tc pulse per period.
  - Stored value 0 in auto-reload: Q stays 0 and tc never fires.
- en=0, load=0: Q holds; tc <= 0.
- Implementation rule for the bit cells:
  - Each Q bit is a T flip-flop.
  - Decrement toggle: T[i] = dec & (Q[i-1:0] == 0), where dec is the decrement condition.
  - Load and reload: T[i] = Q[i] ^ D[i].
  - No bit cell is clocked by another bit.
- Reset mid-count or mid-tc: reset overrides everything; tc drops the same edge.
- Load at Q==1 with en=1: load wins; no tc.
- No X on any output after the first reset edge.

Decomposition:
- Shared package holds:
  - the T-cell width limits (WIDTH_MIN=2, WIDTH_MAX=16);
  - a constant ZERO_VAL = '0 used by the zero compare.
- One sub-module: tff_cell. It has ports clk, reset (synchronous active-low), T, Q, and implements a 1-bit T flip-flop with synchronous reset to 0.
- Generate WIDTH instances of tff_cell; the top level computes the T inputs.

Test Plan (WIDTH=3):
1. Reset: hold reset=0 for 2 edges with load=1, en=1 -> Q=000, zero=1, tc=0 on every edge. Release reset -> counting starts from Q=0 with no tc.
2. One-shot countdown: load_val=101, load 1 cycle, then en=1, auto_reload=0 -> Q sequence 101,100,011,010,001,000,000. tc=1 only on the cycle Q first reads 000; zero=1 from then on.
3. Auto-reload period: load 011, en=1, auto_reload=1 for 12 cycles -> Q repeats 011,010,001,000. tc pulses every 4 cycles, exactly 3 pulses.
4. Enable gating: load 110, toggle en 1,0,1,0 -> Q: 110,101,101,100,100. tc stays 0.
5. Load collision: at Q=001 with en=1, assert load with load_val=111 -> next Q=111, tc=0. Subsequent reloads use 111.
6. Reset mid-operation: drive reset=0 on the edge where Q goes 001->000 -> Q=000, tc=0, and reload register=000. With auto_reload=1, en=1, Q stays 000 and tc never fires.
